// File: rtl/cu_matrix_c_cacheline_write_packer_pkg.sv
// cu_matrix_c_cacheline_write_packer_pkg: shared constants and types for the matrix C write packer.
//   Holds cacheline geometry, the matrix C command tag, the write alignment mask,
//   the packer FSM state type and the write command struct.
package cu_matrix_c_cacheline_write_packer_pkg;
    localparam int CACHELINE_SIZE     = 128;
    localparam int DATA_SIZE_WRITE    = 4;
    localparam int MATRIX_C_ELEM_NUM  = CACHELINE_SIZE / DATA_SIZE_WRITE;
    localparam int MATRIX_C_SLOT_BITS = $clog2(MATRIX_C_ELEM_NUM);
    localparam int BEAT_BITS          = 512;
    localparam logic [7:0]  MATRIX_C_CONTROL_ID           = 8'd3;
    localparam logic [63:0] ADDRESS_DATA_WRITE_ALIGN_MASK = ~64'(CACHELINE_SIZE - 1);
    typedef enum logic [2:0] {IDLE, FILL, CMD, DATA0, DATA1} matrix_c_packer_state_t;
    typedef struct packed {
        logic [63:0]                 address;
        logic [CACHELINE_SIZE-1:0]   byte_enable;
        logic [7:0]                  cu_id;
    } matrix_c_write_cmd_t;
endpackage

// File: rtl/cu_matrix_c_cacheline_write_packer.sv
// cu_matrix_c_cacheline_write_packer: merges 32-bit matrix C elements into 128-byte write lines.
//   clock/rstn (async, active-high) | enabled gates element intake
//   elem_valid/elem_ready/elem_addr/elem_data: element stream in; flush: close partial line
//   cmd_valid/cmd_ready/cmd_address/cmd_byte_enable/cmd_cu_id: one write command per line
//   data_valid/data_ready/data_beat/data_beat_index: two 512-bit beats per line
//   busy, lines_written (wrapping), error_misaligned (sticky)
module cu_matrix_c_cacheline_write_packer
    import cu_matrix_c_cacheline_write_packer_pkg::*;
#(
    parameter logic [7:0] CU_ID = MATRIX_C_CONTROL_ID
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      enabled,
    input  logic                      elem_valid,
    output logic                      elem_ready,
    input  logic [63:0]               elem_addr,
    input  logic [31:0]               elem_data,
    input  logic                      flush,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [63:0]               cmd_address,
    output logic [CACHELINE_SIZE-1:0] cmd_byte_enable,
    output logic [7:0]                cmd_cu_id,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [BEAT_BITS-1:0]      data_beat,
    output logic                      data_beat_index,
    output logic                      busy,
    output logic [31:0]               lines_written,
    output logic                      error_misaligned
);
    matrix_c_packer_state_t      state, state_next;
    matrix_c_write_cmd_t         cmd;
    logic [63:0]                 line_addr;
    logic [2*BEAT_BITS-1:0]      line_buf;
    logic [MATRIX_C_ELEM_NUM-1:0] mask, mask_set;
    logic [MATRIX_C_SLOT_BITS-1:0] slot;
    logic                        flush_pending, aligned, same_line, accept, store;

    assign slot      = elem_addr[6:2];
    assign aligned   = elem_addr[1:0] == 2'b00;
    assign same_line = (elem_addr & ADDRESS_DATA_WRITE_ALIGN_MASK) == line_addr;
    assign accept    = elem_valid && elem_ready;
    // Misaligned elements are consumed but never land in the line.
    assign store     = accept && aligned;
    assign mask_set  = mask | (store ? MATRIX_C_ELEM_NUM'(1) << slot : '0);

    always_comb begin
        state_next = state;
        elem_ready = 1'b0;
        case (state)
            IDLE: begin
                elem_ready = enabled;
                if (store) state_next = FILL;
            end
            FILL: begin
                elem_ready = enabled && same_line && !(&mask);
                // A foreign-line element stalls and closes this line; it is taken from IDLE later.
                if (enabled && (flush || flush_pending || (&mask_set) || (elem_valid && !same_line)))
                    state_next = CMD;
            end
            CMD:     if (cmd_ready) state_next = DATA0;
            DATA0:   if (data_ready) state_next = DATA1;
            DATA1:   if (data_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rstn) begin
        if (rstn) begin
            state            <= IDLE;
            line_addr        <= '0;
            line_buf         <= '0;
            mask             <= '0;
            flush_pending    <= 1'b0;
            lines_written    <= '0;
            error_misaligned <= 1'b0;
        end else begin
            state <= state_next;
            // An empty line swallows flush; a line entering CMD consumes it.
            flush_pending <= (state == IDLE || (state == FILL && state_next == CMD)) ? 1'b0
                           : flush_pending | flush;
            if (accept && !aligned) error_misaligned <= 1'b1;
            if (store) begin
                line_buf[slot*32 +: 32] <= elem_data;
                mask                    <= mask_set;
            end
            if (store && state == IDLE) line_addr <= elem_addr & ADDRESS_DATA_WRITE_ALIGN_MASK;
            if (state == DATA1 && data_ready) begin
                lines_written <= lines_written + 32'd1;
                mask          <= '0;
                line_buf      <= '0;
            end
        end
    end

    for (genvar i = 0; i < MATRIX_C_ELEM_NUM; i++) begin : g_be
        assign cmd.byte_enable[i*4 +: 4] = {4{mask[i]}};
    end
    assign cmd.address      = line_addr;
    assign cmd.cu_id        = CU_ID;
    assign cmd_address      = cmd.address;
    assign cmd_byte_enable  = cmd.byte_enable;
    assign cmd_cu_id        = cmd.cu_id;
    assign cmd_valid        = state == CMD;
    assign data_valid       = state == DATA0 || state == DATA1;
    assign data_beat_index  = state == DATA1;
    assign data_beat        = data_beat_index ? line_buf[2*BEAT_BITS-1:BEAT_BITS] : line_buf[BEAT_BITS-1:0];
    assign busy             = state != IDLE;
endmodule

// File: tb/tb_cu_matrix_c_cacheline_write_packer.sv
// tb_cu_matrix_c_cacheline_write_packer: directed scoreboard bench for the matrix C write packer.
module tb_cu_matrix_c_cacheline_write_packer;
    logic          clock = 1'b0, rstn = 1'b1, enabled = 1'b1, elem_valid = 1'b0, flush = 1'b0;
    logic          cmd_ready = 1'b1, data_ready = 1'b1;
    logic [63:0]   elem_addr = '0;
    logic [31:0]   elem_data = '0;
    logic          elem_ready, cmd_valid, data_valid, data_beat_index, busy, error_misaligned;
    logic [63:0]   cmd_address;
    logic [127:0]  cmd_byte_enable;
    logic [7:0]    cmd_cu_id;
    logic [511:0]  data_beat;
    logic [31:0]   lines_written;

    typedef struct {
        bit           is_beat;
        logic [63:0]  addr;
        logic [127:0] be;
        logic         idx;
        logic [511:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;
    logic [31:0] m_data [32];
    logic [31:0] m_mask = '0;

    cu_matrix_c_cacheline_write_packer dut (
        .clock(clock), .rstn(rstn), .enabled(enabled),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_addr(elem_addr), .elem_data(elem_data),
        .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
        .cmd_byte_enable(cmd_byte_enable), .cmd_cu_id(cmd_cu_id),
        .data_valid(data_valid), .data_ready(data_ready), .data_beat(data_beat),
        .data_beat_index(data_beat_index),
        .busy(busy), .lines_written(lines_written), .error_misaligned(error_misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_data[i] = '0;
        m_mask = '0;
    endtask

    task automatic push_line(input logic [63:0] a);
        exp_t e;
        e.is_beat = 1'b0;
        e.addr = {a[63:7], 7'd0};
        for (int i = 0; i < 32; i++) e.be[i*4 +: 4] = {4{m_mask[i]}};
        e.idx = 1'b0;
        e.data = '0;
        exp_q.push_back(e);
        for (int b = 0; b < 2; b++) begin
            e.is_beat = 1'b1;
            e.idx = b[0];
            for (int i = 0; i < 16; i++) e.data[i*32 +: 32] = m_data[b*16 + i];
            exp_q.push_back(e);
        end
        clear_model();
    endtask

    task automatic send_elem(input logic [63:0] a, input logic [31:0] d);
        int n = 0;
        if (a[1:0] == 2'b00) begin
            m_data[a[6:2]] = d;
            m_mask[a[6:2]] = 1'b1;
        end
        elem_valid = 1'b1;
        elem_addr = a;
        elem_data = d;
        @(negedge clock);
        while (!elem_ready && n < 300) begin
            n++;
            @(negedge clock);
        end
        check("elem_accept", 512'(elem_ready), 512'(1));
        @(posedge clock);
        #1 elem_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy && n < 300) begin
            n++;
            @(negedge clock);
        end
        check("drain_idle", 512'(busy), 512'(0));
    endtask

    // Output monitor: compares every presented command/beat against the queue head,
    // and pops only when the handshake will complete on the coming edge.
    always @(negedge clock) begin
        if (cmd_valid) begin
            if (exp_q.size() == 0 || exp_q[0].is_beat) begin
                check("unexpected_cmd", 512'(1), 512'(0));
            end else begin
                check("cmd_address", 512'(cmd_address), 512'(exp_q[0].addr));
                check("cmd_byte_enable", 512'(cmd_byte_enable), 512'(exp_q[0].be));
                check("cmd_cu_id", 512'(cmd_cu_id), 512'(8'd3));
                if (cmd_ready) void'(exp_q.pop_front());
            end
        end
        if (data_valid) begin
            if (exp_q.size() == 0 || !exp_q[0].is_beat) begin
                check("unexpected_beat", 512'(1), 512'(0));
            end else begin
                check("beat_index", 512'(data_beat_index), 512'(exp_q[0].idx));
                check("beat_data", data_beat, exp_q[0].data);
                if (data_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        clear_model();
        repeat (3) @(posedge clock);
        #1 rstn = 1'b0;
        @(negedge clock);
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_cmd_valid", 512'(cmd_valid), 512'(0));
        check("rst_data_valid", 512'(data_valid), 512'(0));
        check("rst_lines", 512'(lines_written), 512'(0));
        check("rst_error", 512'(error_misaligned), 512'(0));
        @(posedge clock);
        #1;

        // 1: full line of 32 elements
        for (int i = 0; i < 32; i++) begin
            send_elem(64'h1000 + 64'(i * 4), 32'(i));
            if (i == 31) push_line(64'h1000);
        end
        wait_idle();
        check("t1_lines", 512'(lines_written), 512'(1));

        // 2: partial line closed by flush
        send_elem(64'h2000, 32'hA);
        send_elem(64'h2008, 32'hB);
        push_line(64'h2000);
        pulse_flush();
        wait_idle();
        check("t2_lines", 512'(lines_written), 512'(2));

        // 3: foreign-line element stalls until the open line drains
        send_elem(64'h3000, 32'h3);
        push_line(64'h3000);
        elem_valid = 1'b1;
        elem_addr = 64'h3080;
        elem_data = 32'h4;
        @(negedge clock);
        check("t3_stall", 512'(elem_ready), 512'(0));
        send_elem(64'h3080, 32'h4);
        check("t3_busy_new_line", 512'(busy), 512'(1));
        push_line(64'h3080);
        pulse_flush();
        wait_idle();
        check("t3_lines", 512'(lines_written), 512'(4));

        // 4: command back-pressure then toggling data_ready
        cmd_ready = 1'b0;
        data_ready = 1'b0;
        send_elem(64'h5004, 32'h11);
        send_elem(64'h507C, 32'h22);
        push_line(64'h5000);
        pulse_flush();
        repeat (10) @(posedge clock);
        #1 cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1 data_ready = ~data_ready;
        end
        data_ready = 1'b1;
        wait_idle();
        check("t4_queue_empty", 512'(exp_q.size()), 512'(0));
        check("t4_lines", 512'(lines_written), 512'(5));

        // 5: misaligned element is swallowed and flagged
        send_elem(64'h4002, 32'hDEAD);
        check("t5_error", 512'(error_misaligned), 512'(1));
        check("t5_not_busy", 512'(busy), 512'(0));
        pulse_flush();
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("t5_lines", 512'(lines_written), 512'(5));
        check("t5_queue_empty", 512'(exp_q.size()), 512'(0));

        // 6: reset during DATA0
        #1;
        data_ready = 1'b0;
        send_elem(64'h6000, 32'h66);
        push_line(64'h6000);
        pulse_flush();
        begin
            int n = 0;
            while (!data_valid && n < 50) begin
                n++;
                @(negedge clock);
            end
            check("t6_reach_data0", 512'(data_valid), 512'(1));
        end
        @(posedge clock);
        #1 rstn = 1'b1;
        #1;
        check("t6_data_valid_drop", 512'(data_valid), 512'(0));
        exp_q.delete();
        clear_model();
        data_ready = 1'b1;
        @(posedge clock);
        #1 rstn = 1'b0;
        @(negedge clock);
        check("t6_busy", 512'(busy), 512'(0));
        check("t6_lines", 512'(lines_written), 512'(0));
        check("t6_error", 512'(error_misaligned), 512'(0));
        check("t6_data_valid", 512'(data_valid), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
